stream_sink_checker: RTL



---
 rtl/stream_pkg.sv | 18 +
 rtl/stream_sink_checker_if.sv | 22 ++
 rtl/stream_sat_counter.sv | 25 ++
 rtl/stream_sink_checker.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// Shared definitions for the stream sink checker: word width, saturation
// limit and the sink FSM state encoding.
package stream_pkg;

    localparam int WORD_W = 16;

    // All-ones value at which the word and error counters stop.
    localparam logic [WORD_W-1:0] SAT_MAX = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        CHECK = 3'd2,
        GAP   = 3'd3,
        DONE  = 3'd4
    } sink_state_t;

endpackage

// File: rtl/stream_sink_checker_if.sv
// 16-bit stb/ack stream link. The producer drives data and strobe; the
// sink answers with a registered acknowledge.
interface stream_sink_checker_if;
    import stream_pkg::*;

    logic [WORD_W-1:0] input_in;
    logic              input_in_stb;
    logic              input_in_ack;

    modport master (
        output input_in,
        output input_in_stb,
        input  input_in_ack
    );

    modport slave (
        input  input_in,
        input  input_in_stb,
        output input_in_ack
    );

endinterface

// File: rtl/stream_sat_counter.sv
// 16-bit enable-increment counter that sticks at all-ones instead of
// wrapping. Cleared asynchronously while rst is low.
module stream_sat_counter
    import stream_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    output logic [WORD_W-1:0] o_count
);

    logic [WORD_W-1:0] r_count;

    // Count enabled cycles, holding once the ceiling is reached.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_en && (r_count != SAT_MAX)) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/stream_sink_checker.sv
// Consumer end of a 16-bit stb/ack stream. Each accepted word is compared
// with an arithmetic expected sequence (EXPECT_START, +EXPECT_STEP); words
// and mismatches are counted, and done/pass report after EXPECT_COUNT words.
// Build option: define STREAM_SINK_THROTTLE_EN to insert GAP_CYCLES idle
// cycles (ack low) after every checked word.
module stream_sink_checker
    import stream_pkg::*;
#(
    parameter logic [WORD_W-1:0] EXPECT_START = 16'd10,
    parameter logic [WORD_W-1:0] EXPECT_STEP  = 16'd0,
    parameter logic [WORD_W-1:0] EXPECT_COUNT = 16'd1,
    parameter logic [3:0]        GAP_CYCLES   = 4'd0
)
(
    input  logic                  clk,
    input  logic                  rst,
    stream_sink_checker_if.slave  s_in,
    output logic [WORD_W-1:0]     word_count,
    output logic [WORD_W-1:0]     error_count,
    output logic [WORD_W-1:0]     last_value,
    output logic                  mismatch,
    output logic                  done,
    output logic                  pass
);

    sink_state_t       r_state, w_state_next;
    logic              r_ack, w_ack_next;
    logic [WORD_W-1:0] r_last, w_last_next;
    logic [WORD_W-1:0] r_expected, w_expected_next;
    logic              r_mismatch, w_mismatch_next;
    logic              r_done, w_done_next;
    logic              r_pass, w_pass_next;
    logic              w_word_en;
    logic              w_err_en;
    logic              w_transfer;
    logic              w_is_mismatch;
    logic              w_last_word;

`ifdef STREAM_SINK_THROTTLE_EN
    logic [3:0]        r_gap_cnt, w_gap_cnt_next;
`else
    // GAP_CYCLES has no effect in the unthrottled build.
    if (GAP_CYCLES != 4'd0) begin : g_gap_ignored
    end
`endif

    // ack is registered, so a transfer is simply stb seen while ack is high.
    assign w_transfer    = s_in.input_in_stb && r_ack;
    // The reference advances on its own, never from received data.
    assign w_is_mismatch = (r_last != r_expected);
    assign w_last_word   = (EXPECT_COUNT != 16'd0) &&
                           (word_count == (EXPECT_COUNT - 16'd1));

    stream_sat_counter u_word_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_word_en),
        .o_count (word_count)
    );

    stream_sat_counter u_err_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_err_en),
        .o_count (error_count)
    );

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_ack      <= 1'b0;
            r_last     <= '0;
            r_expected <= EXPECT_START;
            r_mismatch <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_ack      <= w_ack_next;
            r_last     <= w_last_next;
            r_expected <= w_expected_next;
            r_mismatch <= w_mismatch_next;
            r_done     <= w_done_next;
            r_pass     <= w_pass_next;
        end
    end

`ifdef STREAM_SINK_THROTTLE_EN
    // Idle-cycle counter used while in GAP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gap_cnt <= 4'd0;
        end else begin
            r_gap_cnt <= w_gap_cnt_next;
        end
    end
`endif

    // Next-state and next-output logic for the sink FSM.
    always_comb begin
        w_state_next    = r_state;
        w_ack_next      = r_ack;
        w_last_next     = r_last;
        w_expected_next = r_expected;
        w_mismatch_next = 1'b0;
        w_done_next     = r_done;
        w_pass_next     = r_pass;
        w_word_en       = 1'b0;
        w_err_en        = 1'b0;
`ifdef STREAM_SINK_THROTTLE_EN
        w_gap_cnt_next  = r_gap_cnt;
`endif
        case (r_state)
            IDLE: begin
                w_state_next = WAIT;
                w_ack_next   = 1'b1;
            end
            WAIT: begin
                if (w_transfer) begin
                    w_last_next  = s_in.input_in;
                    w_ack_next   = 1'b0;
                    w_state_next = CHECK;
                end
            end
            CHECK: begin
                w_word_en       = 1'b1;
                w_expected_next = r_expected + EXPECT_STEP;
                if (w_is_mismatch) begin
                    w_mismatch_next = 1'b1;
                    w_err_en        = 1'b1;
                end
                if (w_last_word) begin
                    w_state_next = DONE;
                    w_done_next  = 1'b1;
                    w_pass_next  = (error_count == 16'd0) && !w_is_mismatch;
                end
`ifdef STREAM_SINK_THROTTLE_EN
                else if (GAP_CYCLES != 4'd0) begin
                    w_state_next   = GAP;
                    w_gap_cnt_next = GAP_CYCLES - 4'd1;
                end
`endif
                else begin
                    w_state_next = WAIT;
                    w_ack_next   = 1'b1;
                end
            end
`ifdef STREAM_SINK_THROTTLE_EN
            GAP: begin
                if (r_gap_cnt == 4'd0) begin
                    w_state_next = WAIT;
                    w_ack_next   = 1'b1;
                end else begin
                    w_gap_cnt_next = r_gap_cnt - 4'd1;
                end
            end
`endif
            DONE: begin
                w_ack_next = 1'b0;
            end
            default: begin
                w_state_next = IDLE;
                w_ack_next   = 1'b0;
            end
        endcase
    end

    assign s_in.input_in_ack = r_ack;
    assign last_value        = r_last;
    assign mismatch          = r_mismatch;
    assign done              = r_done;
    assign pass              = r_pass;

endmodule
